md_issue_ctrl: RTL

//   EX-stage issue controller directly upstream of the HI/LO multiply/divide unit.

---
 rtl/md_issue_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for the HI/LO multiply/divide unit: registers operands,
// launches one op at a time and stalls later HI/LO-class instructions until results commit.
module md_issue_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_md_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        md_busy,
  output logic        md_start,
  output logic [3:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic        md_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  localparam logic [3:0] OP_NEUTRAL = 4'b1111;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          md_start_q, md_start_d;
  logic [3:0]    md_op_q, md_op_d;
  logic [31:0]   md_a_q, md_a_d;
  logic [31:0]   md_b_q, md_b_d;
  logic          md_err_q, md_err_d;

  logic ex_arith, ex_move, ex_read, ex_md_class;
  logic lau_move, lau_div_zero;

  always_comb begin
    ex_arith    = (ex_md_op[3:2] == 2'b00) || (ex_md_op == 4'b1000);
    ex_move     = (ex_md_op == 4'b0100) || (ex_md_op == 4'b0101);
    ex_read     = (ex_md_op == 4'b0110) || (ex_md_op == 4'b0111);
    ex_md_class = ex_arith || ex_move || ex_read;
    // The launched op is still visible in md_op_q during LAUNCH.
    lau_move     = (md_op_q == 4'b0100) || (md_op_q == 4'b0101);
    lau_div_zero = ((md_op_q == 4'b0010) || (md_op_q == 4'b0011)) && (md_b_q == 32'd0);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_d = md_start_q;
    md_op_d    = md_op_q;
    md_a_d     = md_a_q;
    md_b_d     = md_b_q;
    md_err_d   = md_err_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid && ex_arith) begin
          md_a_d     = ex_rs;
          md_b_d     = ex_rt;
          md_op_d    = ex_md_op;
          md_start_d = 1'b1;
          state_d    = S_LAUNCH;
        end else if (ex_valid && ex_move) begin
          md_a_d     = ex_rs;
          md_op_d    = ex_md_op;
          md_start_d = 1'b0;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        md_start_d = 1'b0;
        md_op_d    = OP_NEUTRAL;
        if (lau_move || lau_div_zero) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (!md_busy) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          md_err_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        md_start_d = 1'b0;
        md_op_d    = OP_NEUTRAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      md_start_q <= 1'b0;
      md_op_q    <= OP_NEUTRAL;
      md_a_q     <= 32'd0;
      md_b_q     <= 32'd0;
      md_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_start_q <= md_start_d;
      md_op_q    <= md_op_d;
      md_a_q     <= md_a_d;
      md_b_q     <= md_b_d;
      md_err_q   <= md_err_d;
    end
  end

  assign md_start = md_start_q;
  assign md_op    = md_op_q;
  assign md_a     = md_a_q;
  assign md_b     = md_b_q;
  assign md_err   = md_err_q;
  assign stall    = ex_valid && ex_md_class && (state_q != S_IDLE);

endmodule
